// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at mid-period and
// presents the received byte on data together with a one-cycle load pulse.
module uart_receiver #(
    parameter int B         = 8,
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 9600
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx,
    output logic         load,
    output logic [B-1:0] data,
    output logic         frame_error,
    output logic         busy
);

    localparam int BitCycles = ClockFreq / BaudRate;
    localparam int HalfBit   = BitCycles / 2;
    localparam int CntW      = $clog2(BitCycles);
    localparam int IdxW      = $clog2(B) + 1;

    localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(B - 1);

    if (BitCycles < 4) begin : g_bad_cfg
        $error("uart_receiver: ClockFreq/BaudRate must be at least 4");
    end

    typedef enum logic [2:0] {
        S_Idle,
        S_Start,
        S_Data,
        S_Stop,
        S_Wait
    } state_t;

    state_t            state, state_next;
    logic [CntW-1:0]   cnt, cnt_next;
    logic [IdxW-1:0]   idx, idx_next;
    logic [B-1:0]      shreg, shreg_next;
    logic [B-1:0]      data_next;
    logic              load_next, frame_error_next;
    logic              rx_m, rx_s;

    // Synchronizer presets high so a low line at reset release is not a start bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_Idle;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            data        <= '0;
            load        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shreg       <= shreg_next;
            data        <= data_next;
            load        <= load_next;
            frame_error <= frame_error_next;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        idx_next         = idx;
        shreg_next       = shreg;
        data_next        = data;
        load_next        = 1'b0;
        frame_error_next = 1'b0;

        case (state)
            S_Idle: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = S_Start;
                end
            end
            S_Start: begin
                if (cnt == HalfLast) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rx_s ? S_Idle : S_Data;
                end else begin
                    cnt_next = cnt + CntW'(1);
                end
            end
            S_Data: begin
                if (cnt == BitLast) begin
                    // Right shift: after B bits the first (LSB) bit lands in bit 0
                    shreg_next = {rx_s, shreg[B-1:1]};
                    cnt_next   = '0;
                    idx_next   = idx + IdxW'(1);
                    if (idx == IdxLast) begin
                        state_next = S_Stop;
                    end
                end else begin
                    cnt_next = cnt + CntW'(1);
                end
            end
            S_Stop: begin
                if (cnt == BitLast) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shreg;
                        load_next  = 1'b1;
                        state_next = S_Idle;
                    end else begin
                        frame_error_next = 1'b1;
                        state_next       = S_Wait;
                    end
                end else begin
                    cnt_next = cnt + CntW'(1);
                end
            end
            S_Wait: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = S_Idle;
                end
            end
            default: begin
                state_next = S_Idle;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state != S_Idle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit (1600 Hz / 100 baud).
module tb_uart_receiver;

    logic       clock;
    logic       reset;
    logic       rx;
    logic       load;
    logic [7:0] data;
    logic       frame_error;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc           = 0;
    int load_count    = 0;
    int fe_count      = 0;
    int both_count    = 0;
    int last_load_cyc = -1;
    logic [7:0] load_q[$];

    uart_receiver #(
        .B(8),
        .ClockFreq(1600),
        .BaudRate(100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .load(load),
        .data(data),
        .frame_error(frame_error),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (load) begin
            load_count    <= load_count + 1;
            last_load_cyc <= cyc;
            load_q.push_back(data);
        end
        if (frame_error) fe_count <= fe_count + 1;
        if (load && frame_error) both_count <= both_count + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] value, input logic stop);
        rx = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            rx = value[i];
            wait_cycles(16);
        end
        rx = stop;
        wait_cycles(16);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        wait_cycles(3);
        tests_run++;
        if (load !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_load: got %b expected 0", load);
        end
        tests_run++;
        if (frame_error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_frame_error: got %b expected 0", frame_error);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (data !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h expected 00", data);
        end
        reset = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_single();
        int l0, f0, start_cyc;
        l0        = load_count;
        f0        = fe_count;
        start_cyc = cyc;
        send_frame(8'h24, 1'b1);
        wait_cycles(20);
        tests_run++;
        if (load_count - l0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL single_load_count: got %0d expected 1", load_count - l0);
        end
        tests_run++;
        if (data !== 8'h24) begin
            tests_failed++;
            $display("[TB] FAIL single_data: got %h expected 24", data);
        end
        tests_run++;
        if (fe_count - f0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL single_frame_error: got %0d expected 0", fe_count - f0);
        end
        // rx low at drive, 2 sync flops, E0 on 3rd edge, pulse after E0+152
        tests_run++;
        if (last_load_cyc - start_cyc !== 155) begin
            tests_failed++;
            $display("[TB] FAIL single_latency: got %0d expected 155", last_load_cyc - start_cyc);
        end
    endtask

    task automatic test_glitch();
        int l0, f0;
        l0 = load_count;
        f0 = fe_count;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(2);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL glitch_busy_high: got %b expected 1", busy);
        end
        wait_cycles(20);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_busy_low: got %b expected 0", busy);
        end
        tests_run++;
        if (load_count - l0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_load: got %0d expected 0", load_count - l0);
        end
        tests_run++;
        if (fe_count - f0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_frame_error: got %0d expected 0", fe_count - f0);
        end
    endtask

    task automatic test_frame_error();
        int l0, f0;
        send_frame(8'h47, 1'b1);
        wait_cycles(16);
        l0 = load_count;
        f0 = fe_count;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        wait_cycles(640);
        tests_run++;
        if (fe_count - f0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL ferr_count: got %0d expected 1", fe_count - f0);
        end
        tests_run++;
        if (data !== 8'h47) begin
            tests_failed++;
            $display("[TB] FAIL ferr_data_held: got %h expected 47", data);
        end
        tests_run++;
        if (load_count - l0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL ferr_load: got %0d expected 0", load_count - l0);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ferr_break_busy: got %b expected 1", busy);
        end
        rx = 1'b1;
        wait_cycles(32);
        send_frame(8'h2C, 1'b1);
        wait_cycles(16);
        tests_run++;
        if (load_count - l0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL ferr_recover_load: got %0d expected 1", load_count - l0);
        end
        tests_run++;
        if (data !== 8'h2C) begin
            tests_failed++;
            $display("[TB] FAIL ferr_recover_data: got %h expected 2c", data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [5];
        int l0, f0;
        msg[0] = 8'h47;
        msg[1] = 8'h50;
        msg[2] = 8'h5A;
        msg[3] = 8'h44;
        msg[4] = 8'h41;
        load_q.delete();
        l0 = load_count;
        f0 = fe_count;
        for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1);
        wait_cycles(16);
        tests_run++;
        if (load_count - l0 !== 5) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count: got %0d expected 5", load_count - l0);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (i >= load_q.size()) begin
                tests_failed++;
                $display("[TB] FAIL b2b_byte%0d: got nothing expected %h", i, msg[i]);
            end else if (load_q[i] !== msg[i]) begin
                tests_failed++;
                $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, load_q[i], msg[i]);
            end
        end
        tests_run++;
        if (fe_count - f0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_frame_error: got %0d expected 0", fe_count - f0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] value;
        int l0, f0;
        value = 8'h31;
        l0    = load_count;
        f0    = fe_count;
        rx = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 3; i++) begin
            rx = value[i];
            wait_cycles(16);
        end
        rx = value[3];
        wait_cycles(8);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({load, frame_error, busy} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_flags: got %b expected 000", {load, frame_error, busy});
        end
        tests_run++;
        if (data !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_data: got %h expected 00", data);
        end
        rx = 1'b1;
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(200);
        tests_run++;
        if (load_count - l0 !== 0 || fe_count - f0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_no_pulse: got load %0d ferr %0d expected 0 0",
                     load_count - l0, fe_count - f0);
        end
        send_frame(8'h2A, 1'b1);
        wait_cycles(16);
        tests_run++;
        if (load_count - l0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL rst_after_load: got %0d expected 1", load_count - l0);
        end
        tests_run++;
        if (data !== 8'h2A) begin
            tests_failed++;
            $display("[TB] FAIL rst_after_data: got %h expected 2a", data);
        end
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        @(negedge clock);
        test_reset();
        test_single();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        tests_run++;
        if (both_count !== 0) begin
            tests_failed++;
            $display("[TB] FAIL load_and_ferr_overlap: got %0d expected 0", both_count);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
